// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   start_i      request pulse, sampled only while idle
//   signed_i     1 = two's-complement divide, 0 = unsigned (latched on start)
//   dividend_i   dividend (latched on start)
//   divisor_i    divisor (latched on start)
//   busy_o       operation in flight
//   done_o       one-cycle pulse; results valid from this cycle on
//   quotient_o   registered quotient, held until the next done_o
//   remainder_o  registered remainder, held until the next done_o
//   div_zero_o   last completed operation had a zero divisor
//
// Operands are converted to magnitudes on start, divided unsigned in CALC,
// and the signs are reapplied in FIX. Division by zero skips CALC entirely.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder, always < divisor
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, trial;

    always_comb begin
        a_neg = signed_i & dividend_i[WIDTH-1];
        b_neg = signed_i & divisor_i[WIDTH-1];
        a_abs = a_neg ? -dividend_i : dividend_i;
        b_abs = b_neg ? -divisor_i : divisor_i;
        // Remainder with the next dividend bit shifted in; one extra bit
        // so the trial subtraction sign is exact.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    busy_d    = 1'b1;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    rem_d     = '0;
                    if (divisor_i == '0) begin
                        // quo register keeps the raw dividend for the remainder output
                        dz_d    = 1'b1;
                        quo_d   = dividend_i;
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                div_zero_d = dz_q;
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                end else begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus random operands checked against
// a plain-arithmetic 64-bit reference.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic         signed_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         busy_o, done_o, div_zero_o;
    logic [W-1:0] quotient_o, remainder_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] prev_q = '0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .busy_o(busy_o), .done_o(done_o), .quotient_o(quotient_o),
        .remainder_o(remainder_o), .div_zero_o(div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic, truncating division.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        longint x, y;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            if (s) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'b0, a});
                y = longint'({32'b0, b});
            end
            q = W'(x / y);
            r = W'(x % y);
            dz = 1'b0;
        end
    endfunction

    // Called at a negedge; starts an operation there (back-to-back if the
    // previous one just finished), returns at the negedge where done_o is seen.
    task automatic do_op(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit mid_start);
        logic [W-1:0] eq, er;
        logic edz;
        int cyc, busy_cnt, lat;
        model(s, a, b, eq, er, edz);
        lat = (b == '0) ? 1 : W + 1;
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        @(negedge clk_i);
        start_i = 1'b0;
        dividend_i = $urandom; divisor_i = $urandom; signed_i = ~s;
        cyc = 0; busy_cnt = 0;
        while (!done_o && cyc < 100) begin
            if (busy_o) busy_cnt++;
            if (cyc == 10) chk({tag, "_held"}, {32'b0, quotient_o}, {32'b0, prev_q});
            if (mid_start && cyc == 5) begin
                start_i = 1'b1; signed_i = 1'b0;
                dividend_i = 32'd1000; divisor_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_busy"}, {busy_cnt, busy_o}, {lat, 1'b0});
        chk({tag, "_q"}, {32'b0, quotient_o}, {32'b0, eq});
        chk({tag, "_r"}, {32'b0, remainder_o}, {32'b0, er});
        chk({tag, "_dz"}, {63'b0, div_zero_o}, {63'b0, edz});
        prev_q = eq;
    endtask

    initial begin
        int dn;
        logic [W-1:0] ra, rb;
        logic rs;

        // Reset
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset", {busy_o, done_o, div_zero_o, quotient_o, remainder_o},
                     {3'b000, 32'd0, 32'd0});
        rst_i = 1'b1;
        @(negedge clk_i);

        // Directed
        do_op("u_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        chk("u_100_7_qv", {32'b0, quotient_o}, 64'd14);
        @(negedge clk_i);
        chk("done_pulse", {63'b0, done_o}, 64'd0);
        do_op("s_m7_2", 1'b1, -32'sd7, 32'd2, 1'b0);
        chk("s_m7_2_qv", {32'b0, quotient_o}, 64'hFFFF_FFFD);
        do_op("s_7_m2", 1'b1, 32'd7, -32'sd2, 1'b0);
        do_op("dz_u", 1'b0, 32'd5, 32'd0, 1'b0);
        do_op("after_dz", 1'b0, 32'd9, 32'd3, 1'b0);
        do_op("dz_s", 1'b1, 32'd5, 32'd0, 1'b0);
        do_op("ovf_s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_s_qv", {32'b0, quotient_o}, 64'h8000_0000);
        do_op("ovf_u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("mid_start", 1'b0, 32'd12345, 32'd17, 1'b1);
        @(negedge clk_i);

        // Reset during an operation
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        chk("mid_reset", {busy_o, done_o, div_zero_o, quotient_o, remainder_o},
                         {3'b000, 32'd0, 32'd0});
        prev_q = '0;
        dn = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o || busy_o) dn++;
        end
        chk("no_done_after_reset", 64'(dn), 64'd0);
        do_op("post_reset", 1'b0, 32'd1000, 32'd9, 1'b0);
        do_op("b2b", 1'b1, -32'sd1000, 32'd9, 1'b0);

        // Random
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: rb = -W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
            do_op("rand", rs, ra, rb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
